ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 18 +
 rtl/ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word and handshake state, plus the
// arbiter state encoding and the block beat stride.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE,
      IFETCH,
      DBEAT0,
      DBEAT1
   } arb_state_t;

   localparam word_t BLOCK_STRIDE = 32'd4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: the pointer breaks ties, a lone
// requester always wins, toggle flags that the tie was consumed.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       win,
   output logic       valid,
   output logic       toggle
);

   // Winner selection and pointer-advance request
   always_comb begin
      valid  = |req;
      toggle = &req;
      win    = toggle ? ptr : req[1];
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-core arbiter for a single-port RAM: one-word instruction
// fetches and two-beat data blocks, with instruction anti-starvation.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int AGE_MAX = 8
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [1:0]       iREN,
   input  word_t [1:0]      iaddr,
   input  logic [1:0]       dREN,
   input  logic [1:0]       dWEN,
   input  word_t [1:0]      daddr,
   input  word_t [1:0]      dstore,
   output logic [1:0]       iwait,
   output logic [1:0]       dwait,
   output word_t [1:0]      iload,
   output word_t [1:0]      dload,
   output logic             ramREN,
   output logic             ramWEN,
   output word_t            ramaddr,
   output word_t            ramstore,
   input  word_t            ramload,
   input  ramstate_t        ramstate,
   output logic             gnt_core,
   output logic             gnt_data,
   output logic             ramerr
);

   localparam logic [4:0] AGE_LIM = 5'(AGE_MAX);

   arb_state_t state, nstate;
   logic       iptr, dptr;
   logic [3:0] age;
   logic       gwr;
   logic       iwin, ivld, itog;
   logic       dwin, dvld, dtog;
   logic       take_i, take_d;
   logic       acc, starve;
   logic [1:0] dreq;

   assign acc    = (ramstate == ACCESS);
   assign dreq   = dREN | dWEN;
   assign starve = (|iREN) && ({1'b0, age} >= AGE_LIM);

   rr_pick2 u_ipick (
      .req    (iREN),
      .ptr    (iptr),
      .win    (iwin),
      .valid  (ivld),
      .toggle (itog)
   );

   rr_pick2 u_dpick (
      .req    (dreq),
      .ptr    (dptr),
      .win    (dwin),
      .valid  (dvld),
      .toggle (dtog)
   );

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= nstate;
   end

   // Next state: IDLE arbitrates, grant states advance only on ACCESS
   always_comb begin
      nstate = state;
      take_i = 1'b0;
      take_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (starve) begin
               nstate = IFETCH;
               take_i = 1'b1;
            end else if (dvld) begin
               nstate = DBEAT0;
               take_d = 1'b1;
            end else if (ivld) begin
               nstate = IFETCH;
               take_i = 1'b1;
            end
         end
         IFETCH: if (acc) nstate = IDLE;
         DBEAT0: if (acc) nstate = DBEAT1;
         DBEAT1: if (acc) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Outputs: drive the RAM for the registered grant, pulse its wait
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 2'b11;
      dwait    = 2'b11;
      iload    = '0;
      dload    = '0;
      if (nRST) begin
         unique case (state)
            IFETCH: begin
               ramREN  = 1'b1;
               ramaddr = iaddr[gnt_core];
               if (acc) begin
                  iwait[gnt_core] = 1'b0;
                  iload[gnt_core] = ramload;
               end
            end
            DBEAT0, DBEAT1: begin
               ramREN   = !gwr;
               ramWEN   = gwr;
               ramstore = dstore[gnt_core];
               ramaddr  = (state == DBEAT1)
                        ? daddr[gnt_core] + BLOCK_STRIDE
                        : daddr[gnt_core];
               if (acc) begin
                  dwait[gnt_core] = 1'b0;
                  if (!gwr) dload[gnt_core] = ramload;
               end
            end
            default: ;
         endcase
      end
   end

   // Grant capture and round-robin pointer advance on leaving IDLE
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         gnt_core <= 1'b0;
         gnt_data <= 1'b0;
         gwr      <= 1'b0;
         iptr     <= 1'b0;
         dptr     <= 1'b0;
      end else if (take_i) begin
         gnt_core <= iwin;
         gnt_data <= 1'b0;
         gwr      <= 1'b0;
         if (itog) iptr <= ~iptr;
      end else if (take_d) begin
         gnt_core <= dwin;
         gnt_data <= 1'b1;
         gwr      <= dWEN[dwin];
         if (dtog) dptr <= ~dptr;
      end
   end

   // Instruction age: counts data blocks served while fetches wait
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         age <= '0;
      end else if (state == IFETCH && acc) begin
         age <= '0;
      end else if (state == IDLE && iREN == 2'b00) begin
         age <= '0;
      end else if (state == DBEAT1 && acc && (|iREN)
                   && age != 4'd15) begin
         age <= age + 4'd1;
      end
   end

   // Sticky error flag for RAM errors reported during a grant
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         ramerr <= 1'b0;
      else if (state != IDLE && ramstate == ERROR)
         ramerr <= 1'b1;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: block ordering, wait states,
// address wrap, error flag, starvation and mid-burst reset.
module tb_ram_arbiter;
   import cpu_types_pkg::*;

   logic        CLK;
   logic        nRST;
   logic [1:0]  iREN;
   word_t [1:0] iaddr;
   logic [1:0]  dREN;
   logic [1:0]  dWEN;
   word_t [1:0] daddr;
   word_t [1:0] dstore;
   logic [1:0]  iwait;
   logic [1:0]  dwait;
   word_t [1:0] iload;
   word_t [1:0] dload;
   logic        ramREN;
   logic        ramWEN;
   word_t       ramaddr;
   word_t       ramstore;
   word_t       ramload;
   ramstate_t   ramstate;
   logic        gnt_core;
   logic        gnt_data;
   logic        ramerr;

   int checks;
   int failures;

   localparam word_t LD = 32'hCAFE_0001;

   ram_arbiter #(.AGE_MAX(8)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .iwait    (iwait),
      .dwait    (dwait),
      .iload    (iload),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .gnt_core (gnt_core),
      .gnt_data (gnt_data),
      .ramerr   (ramerr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge CLK);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      nRST     = 1'b0;
      iREN     = '0;
      dREN     = '0;
      dWEN     = '0;
      iaddr    = '0;
      daddr    = '0;
      dstore   = '0;
      ramload  = LD;
      ramstate = FREE;

      // reset state
      step; step; #1;
      chk("rst_ren", 32'(ramREN), 32'd0);
      chk("rst_wen", 32'(ramWEN), 32'd0);
      chk("rst_addr", ramaddr, 32'd0);
      chk("rst_store", ramstore, 32'd0);
      chk("rst_iwait", 32'(iwait), 32'd3);
      chk("rst_dwait", 32'(dwait), 32'd3);
      chk("rst_iload", iload[0], 32'd0);
      chk("rst_gcore", 32'(gnt_core), 32'd0);
      chk("rst_gdata", 32'(gnt_data), 32'd0);
      chk("rst_err", 32'(ramerr), 32'd0);
      step; nRST = 1'b1;

      // both cores read blocks: core0 then core1, 6 cycles
      step;
      dREN = 2'b11;
      daddr[0] = 32'h100;
      daddr[1] = 32'h200;
      ramstate = ACCESS;
      #1;
      chk("rr_c0_ren", 32'(ramREN), 32'd0);
      chk("rr_c0_dwait", 32'(dwait), 32'd3);
      step; #1;
      chk("rr_c1_addr", ramaddr, 32'h100);
      chk("rr_c1_ren", 32'(ramREN), 32'd1);
      chk("rr_c1_dwait", 32'(dwait), 32'd2);
      chk("rr_c1_dload", dload[0], LD);
      chk("rr_c1_gdata", 32'(gnt_data), 32'd1);
      chk("rr_c1_gcore", 32'(gnt_core), 32'd0);
      step; #1;
      chk("rr_c2_addr", ramaddr, 32'h104);
      chk("rr_c2_dwait", 32'(dwait), 32'd2);
      step; #1;
      chk("rr_c3_ren", 32'(ramREN), 32'd0);
      chk("rr_c3_dwait", 32'(dwait), 32'd3);
      step; #1;
      chk("rr_c4_addr", ramaddr, 32'h200);
      chk("rr_c4_gcore", 32'(gnt_core), 32'd1);
      chk("rr_c4_dwait", 32'(dwait), 32'd1);
      chk("rr_c4_dload", dload[1], LD);
      step; dREN = 2'b00; #1;
      chk("rr_c5_addr", ramaddr, 32'h204);
      chk("rr_c5_dwait", 32'(dwait), 32'd1);
      step; #1;
      chk("rr_c6_ren", 32'(ramREN), 32'd0);
      chk("rr_c6_dwait", 32'(dwait), 32'd3);

      // core1 write block with BUSY for 3 cycles on beat 0
      step;
      dWEN = 2'b10;
      daddr[1] = 32'h300;
      dstore[1] = 32'h1234_5678;
      ramstate = BUSY;
      #1;
      chk("bz_idle_wen", 32'(ramWEN), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step; #1;
         chk("bz_wen", 32'(ramWEN), 32'd1);
         chk("bz_ren", 32'(ramREN), 32'd0);
         chk("bz_addr", ramaddr, 32'h300);
         chk("bz_store", ramstore, 32'h1234_5678);
         chk("bz_dwait", 32'(dwait), 32'd3);
      end
      step; ramstate = ACCESS; #1;
      chk("bz_acc_dwait", 32'(dwait), 32'd1);
      chk("bz_acc_wen", 32'(ramWEN), 32'd1);
      chk("bz_acc_dload", dload[1], 32'd0);
      step;
      dWEN = 2'b00;
      dstore[1] = 32'h9ABC_DEF0;
      #1;
      chk("bz_b1_addr", ramaddr, 32'h304);
      chk("bz_b1_store", ramstore, 32'h9ABC_DEF0);
      chk("bz_b1_dwait", 32'(dwait), 32'd1);
      step; #1;
      chk("bz_idle2_wen", 32'(ramWEN), 32'd0);

      // address wrap on the second beat
      step; dREN = 2'b01; daddr[0] = 32'hFFFF_FFF8; #1;
      step; #1;
      chk("wr1_b0", ramaddr, 32'hFFFF_FFF8);
      step; dREN = 2'b00; #1;
      chk("wr1_b1", ramaddr, 32'hFFFF_FFFC);
      step; #1;
      step; dREN = 2'b01; daddr[0] = 32'hFFFF_FFFC; #1;
      step; #1;
      chk("wr2_b0", ramaddr, 32'hFFFF_FFFC);
      step; dREN = 2'b00; #1;
      chk("wr2_b1", ramaddr, 32'h0000_0000);
      step; #1;

      // ERROR during fetch sets the sticky flag
      step; iREN = 2'b01; iaddr[0] = 32'h40; ramstate = FREE; #1;
      step; ramstate = ERROR; #1;
      chk("er_ren", 32'(ramREN), 32'd1);
      chk("er_addr", ramaddr, 32'h40);
      chk("er_iwait", 32'(iwait), 32'd3);
      chk("er_flag0", 32'(ramerr), 32'd0);
      step; ramstate = ACCESS; iREN = 2'b00; #1;
      chk("er_flag1", 32'(ramerr), 32'd1);
      chk("er_iwait_acc", 32'(iwait), 32'd2);
      chk("er_iload", iload[0], LD);
      step; #1;
      chk("er_flag2", 32'(ramerr), 32'd1);
      chk("er_idle_iwait", 32'(iwait), 32'd3);

      // starvation: fetch follows the 8th data block
      step;
      iREN = 2'b01;
      dWEN = 2'b10;
      daddr[1] = 32'h300;
      #1;
      chk("sv_idle_ren", 32'(ramREN), 32'd0);
      for (int k = 0; k < 8; k++) begin
         step; #1;
         chk("sv_blk_gdata", 32'(gnt_data), 32'd1);
         chk("sv_blk_gcore", 32'(gnt_core), 32'd1);
         chk("sv_blk_wen", 32'(ramWEN), 32'd1);
         step;
         step; #1;
         chk("sv_idle", 32'(ramWEN | ramREN), 32'd0);
      end
      step; #1;
      chk("sv_if_gdata", 32'(gnt_data), 32'd0);
      chk("sv_if_gcore", 32'(gnt_core), 32'd0);
      chk("sv_if_ren", 32'(ramREN), 32'd1);
      chk("sv_if_addr", ramaddr, 32'h40);
      chk("sv_if_iwait", 32'(iwait), 32'd2);
      chk("sv_if_dwait", 32'(dwait), 32'd3);
      step; #1;
      step; iREN = 2'b00; dWEN = 2'b00; #1;
      chk("sv_after_gdata", 32'(gnt_data), 32'd1);
      chk("sv_after_wen", 32'(ramWEN), 32'd1);
      step;
      step; #1;
      chk("sv_end_wen", 32'(ramWEN), 32'd0);

      // instruction round-robin between both cores
      step; iREN = 2'b11; iaddr[1] = 32'h80; #1;
      step; #1;
      chk("ir_c0_addr", ramaddr, 32'h40);
      chk("ir_c0_iwait", 32'(iwait), 32'd2);
      step; #1;
      step; iREN = 2'b00; #1;
      chk("ir_c1_addr", ramaddr, 32'h80);
      chk("ir_c1_iwait", 32'(iwait), 32'd1);
      chk("ir_c1_iload", iload[1], LD);
      step; #1;
      chk("ir_err_kept", 32'(ramerr), 32'd1);

      // reset asserted during beat 1 abandons the block
      step; dREN = 2'b01; daddr[0] = 32'h500; #1;
      step; #1;
      chk("mr_b0_addr", ramaddr, 32'h500);
      step; nRST = 1'b0; #1;
      chk("mr_ren", 32'(ramREN), 32'd0);
      chk("mr_wen", 32'(ramWEN), 32'd0);
      chk("mr_dwait", 32'(dwait), 32'd3);
      chk("mr_addr", ramaddr, 32'd0);
      chk("mr_dload", dload[0], 32'd0);
      chk("mr_gdata", 32'(gnt_data), 32'd0);
      chk("mr_err", 32'(ramerr), 32'd0);
      step; nRST = 1'b1; dREN = 2'b00; #1;
      chk("mr_rel_ren", 32'(ramREN), 32'd0);
      chk("mr_rel_dwait", 32'(dwait), 32'd3);
      step; #1;
      chk("mr_idle_ren", 32'(ramREN), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
